// File: rtl/rf_write_arbiter.sv
// Three-way round-robin register-file write arbiter: combinational grant, 1-cycle registered write.
// Requesters hold valid/addr/data until granted; at most one transfer per cycle, no bubbles.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [1:0]            rf_wsrc,
    output logic [7:0]            conflict_cnt
);

    logic [1:0]        ptr;
    logic [1:0]        win;
    logic              xfer;
    logic              contended;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        ptr_next;

    // Search order starts at ptr and wraps modulo 3.
    always_comb begin
        req_ready = 3'b000;
        if (!reset) begin
            case (ptr)
                2'd1: begin
                    if      (req_valid[1]) req_ready = 3'b010;
                    else if (req_valid[2]) req_ready = 3'b100;
                    else if (req_valid[0]) req_ready = 3'b001;
                end
                2'd2: begin
                    if      (req_valid[2]) req_ready = 3'b100;
                    else if (req_valid[0]) req_ready = 3'b001;
                    else if (req_valid[1]) req_ready = 3'b010;
                end
                default: begin
                    if      (req_valid[0]) req_ready = 3'b001;
                    else if (req_valid[1]) req_ready = 3'b010;
                    else if (req_valid[2]) req_ready = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        win      = 2'd0;
        sel_addr = req_addr[0 +: ADDR_W];
        sel_data = req_data[0 +: DATA_W];
        ptr_next = 2'd1;
        if (req_ready[1]) begin
            win      = 2'd1;
            sel_addr = req_addr[ADDR_W +: ADDR_W];
            sel_data = req_data[DATA_W +: DATA_W];
            ptr_next = 2'd2;
        end else if (req_ready[2]) begin
            win      = 2'd2;
            sel_addr = req_addr[2*ADDR_W +: ADDR_W];
            sel_data = req_data[2*DATA_W +: DATA_W];
            ptr_next = 2'd0;
        end
    end

    assign xfer      = |req_ready;
    assign contended = (req_valid[0] & req_valid[1]) |
                       (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= 2'd0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_wsrc      <= 2'd0;
            conflict_cnt <= 8'd0;
        end else begin
            rf_we <= 1'b0;
            if (xfer) begin
                ptr      <= ptr_next;
                // Register 0 is hardwired to zero: accept the write but suppress the enable.
                rf_we    <= (sel_addr != '0);
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                rf_wsrc  <= win;
            end
            if (contended && conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural round-robin model.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic [2:0]          req_valid;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          req_ready;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [1:0]          rf_wsrc;
    logic [7:0]          conflict_cnt;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_wsrc(rf_wsrc), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the registered outputs must be during the current cycle.
    int               m_ptr = 0;
    logic             m_we = 1'b0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    int               m_wsrc = 0;
    int               m_cnt = 0;
    logic [2:0]       m_last_gnt = 3'b000;

    always @(negedge clk) begin
        int  winner;
        int  nvalid;
        logic [2:0] g;
        winner = -1;
        nvalid = 0;
        g = 3'b000;
        for (int i = 0; i < 3; i++) if (req_valid[i]) nvalid++;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (winner < 0 && req_valid[(m_ptr + k) % 3]) winner = (m_ptr + k) % 3;
            end
        end
        if (winner >= 0) g[winner] = 1'b1;

        chk("req_ready", {61'd0, req_ready}, {61'd0, g});
        chk("rf_we", {63'd0, rf_we}, {63'd0, m_we});
        chk("rf_waddr", {58'd0, rf_waddr}, {58'd0, m_waddr});
        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
        chk("rf_wsrc", {62'd0, rf_wsrc}, m_wsrc);
        chk("conflict_cnt", {56'd0, conflict_cnt}, m_cnt);

        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_wsrc = 0; m_cnt = 0;
        end else begin
            m_we = 1'b0;
            if (winner >= 0) begin
                m_waddr = req_addr[winner*ADDR_W +: ADDR_W];
                m_wdata = req_data[winner*DATA_W +: DATA_W];
                m_we    = (m_waddr != 0);
                m_wsrc  = winner;
                m_ptr   = (winner + 1) % 3;
            end
            if (nvalid >= 2 && m_cnt < 255) m_cnt++;
        end
        m_last_gnt = g;
    end

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 3'b000;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic at_sample();
        @(negedge clk); #1;
    endtask

    task automatic next_drive();
        @(posedge clk); #1;
    endtask

    initial begin
        int ord [6];
        int ngr [3];
        reset = 1'b1;
        req_valid = 3'b000;
        req_addr = '0;
        req_data = '0;
        ord = '{0, 1, 2, 0, 1, 2};

        repeat (2) @(posedge clk);
        at_sample();
        chk("reset_ready", {61'd0, req_ready}, 64'd0);
        chk("reset_we", {63'd0, rf_we}, 64'd0);
        chk("reset_cnt", {56'd0, conflict_cnt}, 64'd0);

        // Single write.
        next_drive();
        reset = 1'b0;
        set_req(0, 1'b1, 6'd5, 32'hDEADBEEF);
        at_sample();
        chk("single_ready", {61'd0, req_ready}, 64'h1);
        next_drive();
        req_valid = 3'b000;
        at_sample();
        chk("single_we", {63'd0, rf_we}, 64'd1);
        chk("single_waddr", {58'd0, rf_waddr}, 64'd5);
        chk("single_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
        chk("single_wsrc", {62'd0, rf_wsrc}, 64'd0);
        next_drive();
        at_sample();
        chk("single_we_after", {63'd0, rf_we}, 64'd0);

        // Fairness, all held.
        do_reset();
        set_req(0, 1'b1, 6'd10, 32'hA0);
        set_req(1, 1'b1, 6'd11, 32'hA1);
        set_req(2, 1'b1, 6'd12, 32'hA2);
        for (int k = 0; k < 6; k++) begin
            at_sample();
            chk("rr_order", {61'd0, req_ready}, 64'd1 << ord[k]);
            next_drive();
        end
        at_sample();
        chk("rr_cnt6", {56'd0, conflict_cnt}, 64'd6);

        // Fairness, each requester drops after its second grant.
        do_reset();
        set_req(0, 1'b1, 6'd20, 32'hB0);
        set_req(1, 1'b1, 6'd21, 32'hB1);
        set_req(2, 1'b1, 6'd22, 32'hB2);
        ngr = '{0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            at_sample();
            chk("rr_drop_order", {61'd0, req_ready}, 64'd1 << ord[k]);
            next_drive();
            ngr[ord[k]]++;
            if (ngr[ord[k]] == 2) req_valid[ord[k]] = 1'b0;
        end
        at_sample();
        chk("rr_drop_cnt5", {56'd0, conflict_cnt}, 64'd5);

        // Write to register 0, then the pointer must sit at 2.
        do_reset();
        set_req(1, 1'b1, 6'd0, 32'h1234);
        at_sample();
        chk("zero_ready", {61'd0, req_ready}, 64'h2);
        next_drive();
        req_valid = 3'b000;
        at_sample();
        chk("zero_we", {63'd0, rf_we}, 64'd0);
        chk("zero_waddr", {58'd0, rf_waddr}, 64'd0);
        chk("zero_wdata", {32'd0, rf_wdata}, 64'h1234);
        chk("zero_wsrc", {62'd0, rf_wsrc}, 64'd1);
        next_drive();
        set_req(0, 1'b1, 6'd1, 32'h1);
        set_req(1, 1'b1, 6'd2, 32'h2);
        set_req(2, 1'b1, 6'd3, 32'h3);
        at_sample();
        chk("zero_ptr2", {61'd0, req_ready}, 64'h4);
        next_drive();
        req_valid = 3'b000;

        // Saturation with two requesters held for 300 cycles.
        do_reset();
        set_req(0, 1'b1, 6'd30, 32'hC0);
        set_req(1, 1'b1, 6'd31, 32'hC1);
        for (int k = 0; k < 300; k++) begin
            at_sample();
            chk("sat_alt", {61'd0, req_ready}, 64'd1 << (k % 2));
            if (k == 280) chk("sat_cnt_280", {56'd0, conflict_cnt}, 64'd255);
            next_drive();
        end
        at_sample();
        chk("sat_cnt_end", {56'd0, conflict_cnt}, 64'd255);

        // Reset arriving right after a transfer.
        do_reset();
        set_req(0, 1'b1, 6'd7, 32'h77);
        next_drive();
        reset = 1'b1;
        set_req(1, 1'b1, 6'd8, 32'h88);
        set_req(2, 1'b1, 6'd9, 32'h99);
        at_sample();
        chk("mid_we_before", {63'd0, rf_we}, 64'd1);
        chk("mid_ready_in_reset", {61'd0, req_ready}, 64'd0);
        next_drive();
        reset = 1'b0;
        at_sample();
        chk("mid_we", {63'd0, rf_we}, 64'd0);
        chk("mid_waddr", {58'd0, rf_waddr}, 64'd0);
        chk("mid_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("mid_wsrc", {62'd0, rf_wsrc}, 64'd0);
        chk("mid_cnt", {56'd0, conflict_cnt}, 64'd0);
        chk("mid_grant0", {61'd0, req_ready}, 64'h1);
        next_drive();
        req_valid = 3'b000;

        // Randomized traffic; requesters hold until the model says they were granted.
        for (int k = 0; k < 3000; k++) begin
            next_drive();
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && m_last_gnt[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, 1'b1,
                            ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom),
                            32'($urandom));
                end
            end
        end
        next_drive();
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
